ageb2_serial_cmp: RTL and testbench

- Multi-cycle magnitude comparator that answers the opposite relation to the ALEB2 carry-chain slice: it computes A >= B.
- It walks the operands two bits per cycle, LSB-first, through a single registered greater-or-equal carry stage.
- It trades latency for area in wide compares, e.g. FIFO threshold and counter-limit checks, where a full-width combinational chain is not wanted.
- START/DONE pulse handshake; result is held until the next compare.

---
 rtl/ageb2_serial_cmp.sv | 137 +++++++++++++
 tb/tb_ageb2_serial_cmp.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ageb2_serial_cmp.sv
`default_nettype none
// ============================================================================
// Module   : ageb2_serial_cmp
// Purpose  : Serial A >= B magnitude comparator. Consumes two operand bits
//            per cycle, LSB-first, through one registered GE carry stage.
//            Define SERIAL_CMP_SIGNED_EN for two's-complement operands.
// Revision : 1.0 - initial release
// ============================================================================
module ageb2_serial_cmp #(
    parameter int WIDTH = 16
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             START,
    input  logic             CI,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             READY,
    output logic             DONE,
    output logic             GE
);

    localparam int NSLICE  = WIDTH / 2;
    localparam int C_CNT_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(NSLICE - 1);
    localparam logic [C_CNT_W-1:0] C_ONE  = C_CNT_W'(1);

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $fatal(1, "ageb2_serial_cmp: WIDTH must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_step;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic               r_carry;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_ge;
    logic [WIDTH-1:0]   w_a_cap;
    logic [WIDTH-1:0]   w_b_cap;
    logic               w_c0;
    logic               w_carry_nxt;
    logic               w_last;

`ifdef SERIAL_CMP_SIGNED_EN
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] C_SIGN = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_a_cap = A ^ C_SIGN;
    assign w_b_cap = B ^ C_SIGN;
`else
    assign w_a_cap = A;
    assign w_b_cap = B;
`endif

    // Two chained GE cells: low bit of the slice first, then the high bit.
    assign w_c0        = (r_sa[0] & ~r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_carry);
    assign w_carry_nxt = (r_sa[1] & ~r_sb[1]) | (~(r_sa[1] ^ r_sb[1]) & w_c0);
    assign w_last      = (r_cnt == C_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (START) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_ge    <= 1'b0;
        end else if (w_load) begin
            r_sa    <= w_a_cap;
            r_sb    <= w_b_cap;
            r_carry <= CI;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_sa    <= r_sa >> 2;
            r_sb    <= r_sb >> 2;
            r_carry <= w_carry_nxt;
            r_cnt   <= r_cnt + C_ONE;
            if (w_last) begin
                r_ge <= w_carry_nxt;
            end
        end
    end

    assign READY = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign DONE  = (r_state == ST_DONE);
    assign GE    = r_ge;

endmodule
`default_nettype wire

// File: tb/tb_ageb2_serial_cmp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ageb2_serial_cmp
// Purpose  : Directed and randomised checks of ageb2_serial_cmp at WIDTH=16
//            and WIDTH=2; honours SERIAL_CMP_SIGNED_EN in its expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ageb2_serial_cmp;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ci;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic         ge;
    logic         start2;
    logic         ci2;
    logic [1:0]   a2;
    logic [1:0]   b2;
    logic         ready2;
    logic         done2;
    logic         ge2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ageb2_serial_cmp #(.WIDTH(W)) u_dut16 (
        .CK(clk), .CD(rst), .START(start), .CI(ci), .A(a), .B(b),
        .READY(ready), .DONE(done), .GE(ge)
    );

    ageb2_serial_cmp #(.WIDTH(2)) u_dut2 (
        .CK(clk), .CD(rst), .START(start2), .CI(ci2), .A(a2), .B(b2),
        .READY(ready2), .DONE(done2), .GE(ge2)
    );

    function automatic logic model16(input logic [15:0] x, input logic [15:0] y, input logic c);
`ifdef SERIAL_CMP_SIGNED_EN
        return c ? ($signed(x) >= $signed(y)) : ($signed(x) > $signed(y));
`else
        return c ? (x >= y) : (x > y);
`endif
    endfunction

    function automatic logic model2(input logic [1:0] x, input logic [1:0] y, input logic c);
`ifdef SERIAL_CMP_SIGNED_EN
        return c ? ($signed(x) >= $signed(y)) : ($signed(x) > $signed(y));
`else
        return c ? (x >= y) : (x > y);
`endif
    endfunction

    // Issues one compare; lat counts sample points from acceptance to DONE.
    task automatic run16(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         output int lat, output logic res);
        @(negedge clk);
        start = 1'b1; a = va; b = vb; ci = vc;
        @(negedge clk);
        start = 1'b0; a = ~va; b = ~vb; ci = ~vc;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = ge;
    endtask

    task automatic run2(input logic [1:0] va, input logic [1:0] vb, input logic vc,
                        output int lat, output logic res);
        @(negedge clk);
        start2 = 1'b1; a2 = va; b2 = vb; ci2 = vc;
        @(negedge clk);
        start2 = 1'b0; a2 = ~va; b2 = ~vb;
        lat = 0;
        while (!done2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = ge2;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        a = '0; b = '0; ci = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (ge !== 1'b0) begin n_err++; $display("FAIL reset_ge: got %b want 0", ge); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", ready); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL release_done: got %b want 0", done); end
        n_vec++; if (ge !== 1'b0) begin n_err++; $display("FAIL release_ge: got %b want 0", ge); end
    endtask

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vc;
        logic        exp_u;
        logic        exp_s;
    } vec_t;

    task automatic test_directed();
        vec_t vt[9];
        int   lat;
        logic res;
        logic exp;
        vt[0] = '{16'h1234, 16'h1233, 1'b1, 1'b1, 1'b1};
        vt[1] = '{16'h8000, 16'h8000, 1'b1, 1'b1, 1'b1};
        vt[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0};
        vt[3] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0};
        vt[4] = '{16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0};
        vt[5] = '{16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0};
        vt[6] = '{16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1};
        vt[7] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vt[8] = '{16'h0100, 16'h00FF, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 9; i++) begin
`ifdef SERIAL_CMP_SIGNED_EN
            exp = vt[i].exp_s;
`else
            exp = vt[i].exp_u;
`endif
            run16(vt[i].va, vt[i].vb, vt[i].vc, lat, res);
            n_vec++;
            if (lat !== 8) begin n_err++; $display("FAIL dir%0d_latency: got %0d want 8", i, lat); end
            n_vec++;
            if (res !== exp) begin n_err++; $display("FAIL dir%0d_ge: got %b want %b", i, res, exp); end
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, done); end
            n_vec++;
            if (ge !== exp) begin n_err++; $display("FAIL dir%0d_ge_hold: got %b want %b", i, ge, exp); end
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        int   extra;
        logic res;
        run16(16'h0001, 16'h0002, 1'b1, lat, res);
        n_vec++; if (res !== 1'b0) begin n_err++; $display("FAIL b2b_first_ge: got %b want 0", res); end
        // Restart while DONE is high.
        start = 1'b1; a = 16'h0002; b = 16'h0001; ci = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'h0000; b = 16'hFFFF;
        lat = 1;
        n_vec++; if (ge !== 1'b0) begin n_err++; $display("FAIL b2b_ge_not_cleared: got %b want 0", ge); end
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            start = (lat == 3);
        end
        start = 1'b0;
        n_vec++; if (lat !== 9) begin n_err++; $display("FAIL b2b_spacing: got %0d want 9", lat); end
        n_vec++; if (ge !== 1'b1) begin n_err++; $display("FAIL b2b_second_ge: got %b want 1", ge); end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra++;
        end
        n_vec++; if (extra !== 0) begin n_err++; $display("FAIL b2b_no_extra_done: got %0d want 0", extra); end
    endtask

    task automatic test_abort();
        int   lat;
        int   seen;
        logic res;
        @(negedge clk);
        start = 1'b1; a = 16'h0000; b = 16'h0001; ci = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b want 1", ready); end
        n_vec++; if (ge !== 1'b0) begin n_err++; $display("FAIL abort_ge: got %b want 0", ge); end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", seen); end
        run16(16'd5, 16'd3, 1'b1, lat, res);
        n_vec++; if (lat !== 8) begin n_err++; $display("FAIL abort_restart_latency: got %0d want 8", lat); end
        n_vec++; if (res !== 1'b1) begin n_err++; $display("FAIL abort_restart_ge: got %b want 1", res); end
    endtask

    task automatic test_random16();
        int          lat;
        logic        res;
        logic        exp;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = (i % 8 == 0) ? ra : 16'($urandom);
            if (i % 5 == 1) rb = ra ^ 16'(1 << (i % 16));
            rc = 1'($urandom);
            exp = model16(ra, rb, rc);
            run16(ra, rb, rc, lat, res);
            n_vec++;
            if (lat !== 8) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want 8", i, lat); end
            n_vec++;
            if (res !== exp) begin
                n_err++;
                $display("FAIL rnd%0d_ge a=%h b=%h ci=%b: got %b want %b", i, ra, rb, rc, res, exp);
            end
        end
    endtask

    task automatic test_width2();
        int   lat;
        logic res;
        logic exp;
        for (int i = 0; i < 32; i++) begin
            exp = model2(2'(i >> 3), 2'(i >> 1), 1'(i));
            n_vec++;
            if (ready2 !== 1'b1) begin n_err++; $display("FAIL w2_%0d_ready: got %b want 1", i, ready2); end
            run2(2'(i >> 3), 2'(i >> 1), 1'(i), lat, res);
            n_vec++;
            if (lat !== 1) begin n_err++; $display("FAIL w2_%0d_latency: got %0d want 1", i, lat); end
            n_vec++;
            if (res !== exp) begin n_err++; $display("FAIL w2_%0d_ge: got %b want %b", i, res, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_random16();
        test_width2();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
